// File: rtl/i2c_controller.sv
// i2c_controller
//   Write-only I2C master. Each request sends one 3-byte write:
//   slave address/RW, sub-address, then data. All bytes go out MSB first.
//   One I2C bit takes two CLOCK cycles (SCL low phase, then SCL high phase).
//
// Ports
//   CLOCK     work clock; also paces SCL
//   RESET     synchronous, active-high reset
//   I2C_SCLK  I2C clock, registered
//   I2C_SDAT  I2C data, open-drain (drives 0 or releases to Z)
//   I2C_DATA  {slave_addr_rw, sub_addr, data}; latched when a transfer starts
//   GO        level request: high runs or holds a transfer, low idles or aborts
//   END       high once the transfer is complete, for as long as GO stays high
//   ACK       OR of the three sampled acknowledge bits (1 = some byte NACKed)
module i2c_controller (
    input  logic        CLOCK,
    input  logic        RESET,
    output logic        I2C_SCLK,
    inout  wire         I2C_SDAT,
    input  logic [23:0] I2C_DATA,
    input  logic        GO,
    output logic        END,
    output logic        ACK
);

    // Step-counter values that sequence one transfer.
    localparam logic [6:0] STEP_IDLE      = 7'd0;
    localparam logic [6:0] STEP_START     = 7'd1;
    localparam logic [6:0] STEP_FIRST_LOW = 7'd2;
    localparam logic [6:0] STEP_BIT_LAST  = 7'd56;
    localparam logic [6:0] STEP_STOP_LOW  = 7'd57;
    localparam logic [6:0] STEP_STOP_HIGH = 7'd58;
    localparam logic [6:0] STEP_STOP      = 7'd59;
    localparam logic [6:0] STEP_DONE      = 7'd60;

    // Each acknowledge is sampled on the edge that ends its SCL-high phase
    // (the same edge that pulls SCL low again), so the slave still drives it.
    localparam logic [6:0] STEP_ACK1 = 7'd21;
    localparam logic [6:0] STEP_ACK2 = 7'd39;
    localparam logic [6:0] STEP_ACK3 = 7'd57;

    logic [6:0]  stepCnt;
    logic [23:0] txData;
    logic        sdaOut;
    logic        ack1;
    logic        ack2;
    logic        ack3;

    logic [5:0]  slotOfs;
    logic [4:0]  slot;
    logic [1:0]  byteIdx;
    logic [4:0]  byteBase;
    logic [4:0]  slotPos;
    logic [4:0]  bitIdx;
    logic        slotSda;

    assign I2C_SDAT = sdaOut ? 1'bz : 1'b0;
    assign ACK      = ack1 | ack2 | ack3;

    // Bit-slot decode for steps 3..56: slot = (c-3)/2, byte = slot/9,
    // position = slot%9. Position 8 is the acknowledge slot (SDA released).
    always_comb begin
        slotOfs = stepCnt[5:0] - 6'd3;
        slot    = slotOfs[5:1];
        if (slot >= 5'd18) begin
            byteIdx  = 2'd2;
            byteBase = 5'd18;
        end else if (slot >= 5'd9) begin
            byteIdx  = 2'd1;
            byteBase = 5'd9;
        end else begin
            byteIdx  = 2'd0;
            byteBase = 5'd0;
        end
        slotPos = slot - byteBase;
        bitIdx  = 5'd23 - {byteIdx, 3'b000} - slotPos;
        slotSda = (slotPos == 5'd8) ? 1'b1 : txData[bitIdx];
    end

    // Bus outputs are registered from the current step, so the pins show
    // step c during the cycle after c was reached. GO low and RESET bypass
    // this and idle the bus on the edge that sees them.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            stepCnt  <= STEP_IDLE;
            I2C_SCLK <= 1'b1;
            sdaOut   <= 1'b1;
            END      <= 1'b0;
            ack1     <= 1'b0;
            ack2     <= 1'b0;
            ack3     <= 1'b0;
        end else if (!GO) begin
            stepCnt  <= STEP_IDLE;
            I2C_SCLK <= 1'b1;
            sdaOut   <= 1'b1;
            END      <= 1'b0;
            // ACK stays readable until the controller has actually sat in idle.
            if (stepCnt == STEP_IDLE) begin
                ack1 <= 1'b0;
                ack2 <= 1'b0;
                ack3 <= 1'b0;
            end
        end else begin
            if (stepCnt != STEP_DONE) begin
                stepCnt <= stepCnt + 7'd1;
            end

            if (stepCnt == STEP_IDLE) begin
                txData   <= I2C_DATA;
                I2C_SCLK <= 1'b1;
                sdaOut   <= 1'b1;
                END      <= 1'b0;
                ack1     <= 1'b0;
                ack2     <= 1'b0;
                ack3     <= 1'b0;
            end else if (stepCnt == STEP_START) begin
                I2C_SCLK <= 1'b1;
                sdaOut   <= 1'b0;
            end else if (stepCnt == STEP_FIRST_LOW) begin
                I2C_SCLK <= 1'b0;
                sdaOut   <= 1'b0;
            end else if (stepCnt <= STEP_BIT_LAST) begin
                if (!slotOfs[0]) begin
                    I2C_SCLK <= 1'b0;
                    sdaOut   <= slotSda;
                end else begin
                    I2C_SCLK <= 1'b1;
                end
            end else if (stepCnt == STEP_STOP_LOW) begin
                I2C_SCLK <= 1'b0;
                sdaOut   <= 1'b0;
            end else if (stepCnt == STEP_STOP_HIGH) begin
                I2C_SCLK <= 1'b1;
                sdaOut   <= 1'b0;
            end else if (stepCnt == STEP_STOP) begin
                I2C_SCLK <= 1'b1;
                sdaOut   <= 1'b1;
            end else begin
                I2C_SCLK <= 1'b1;
                sdaOut   <= 1'b1;
                END      <= 1'b1;
            end

            if (stepCnt == STEP_ACK1) ack1 <= I2C_SDAT;
            if (stepCnt == STEP_ACK2) ack2 <= I2C_SDAT;
            if (stepCnt == STEP_ACK3) ack3 <= I2C_SDAT;
        end
    end

endmodule

// File: tb/tb_i2c_controller.sv
// tb_i2c_controller
//   Directed/randomized bench for i2c_controller. A bus-level slave watches
//   SCL/SDA, decodes START/STOP and the 27 clocked bits of each frame, and
//   acknowledges bytes according to a per-transaction NACK plan. Expected
//   frames, ACK status and END timing come from the protocol rules.
module tb_i2c_controller;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        GO = 1'b0;
    logic [23:0] I2C_DATA = 24'h0;
    logic        I2C_SCLK;
    logic        END;
    logic        ACK;
    wire         sdaBus;

    pullup (sdaBus);

    logic slavePull = 1'b0;
    assign sdaBus = slavePull ? 1'b0 : 1'bz;

    i2c_controller dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .I2C_SCLK (I2C_SCLK),
        .I2C_SDAT (sdaBus),
        .I2C_DATA (I2C_DATA),
        .GO       (GO),
        .END      (END),
        .ACK      (ACK)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;

    // Slave / bus monitor state
    int          startCount = 0;
    int          stopCount = 0;
    int          bitCnt = 0;
    int          lastBitCnt = 0;
    logic        inFrame = 1'b0;
    logic [26:0] bits = '0;
    logic [26:0] lastFrame = '0;
    logic [2:0]  nackPlan = 3'b000;   // bit k set: NACK byte k (0 = address byte)
    logic        prevScl = 1'b1;
    logic        prevSda = 1'b1;
    logic        sclNow;
    logic        sdaNow;

    // Sampled mid-cycle, well away from the DUT's active edge.
    always @(negedge CLOCK) begin
        sclNow = (I2C_SCLK === 1'b0) ? 1'b0 : 1'b1;
        sdaNow = (sdaBus === 1'b0) ? 1'b0 : 1'b1;
        if (sclNow && prevScl && prevSda && !sdaNow) begin
            inFrame = 1'b1;
            bitCnt = 0;
            bits = '0;
            startCount++;
        end else if (sclNow && prevScl && !prevSda && sdaNow) begin
            if (inFrame) begin
                stopCount++;
                lastFrame = bits;
                lastBitCnt = bitCnt;
            end
            inFrame = 1'b0;
        end else if (inFrame && sclNow && !prevScl && bitCnt < 27) begin
            bits[26 - bitCnt] = sdaNow;
            bitCnt++;
        end
        // Drive the acknowledge only while SCL is low; hold it through high.
        if (!sclNow) begin
            slavePull = inFrame && (bitCnt % 9 == 8) && !nackPlan[bitCnt / 9];
        end
        // The host abandoned the transfer: let go of the bus.
        if (!GO) begin
            slavePull = 1'b0;
            inFrame = 1'b0;
        end
        prevScl = sclNow;
        prevSda = sdaNow;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    function automatic logic [26:0] expFrame(input logic [23:0] d, input logic [2:0] nack);
        return {d[23:16], nack[0], d[15:8], nack[1], d[7:0], nack[2]};
    endfunction

    // Called #1 after an edge. Raises GO, runs one transfer to END, checks
    // frame/ACK/latency, then lowers GO and checks the return to idle.
    task automatic runTxn(input logic [23:0] d, input logic [2:0] nack);
        int sb;
        int eb;
        int cycles;
        I2C_DATA = d;
        nackPlan = nack;
        RESET = 1'b0;
        GO = 1'b1;
        sb = startCount;
        eb = stopCount;
        tick();                       // edge where GO is first sampled high
        check("end_low_after_go", {31'd0, END}, 32'd0);
        cycles = 0;
        while (END !== 1'b1 && cycles < 200) begin
            tick();
            cycles++;
        end
        check("end_latency", cycles, 32'd60);
        check("ack_status", {31'd0, ACK}, {31'd0, |nack});
        check("start_count", startCount, sb + 1);
        check("stop_count", stopCount, eb + 1);
        check("frame_bits", lastBitCnt, 32'd27);
        check("frame_data", {5'd0, lastFrame}, {5'd0, expFrame(d, nack)});
        check("idle_at_end", {30'd0, I2C_SCLK, sdaBus}, 32'd3);
        tick();
        check("end_still_high", {31'd0, END}, 32'd1);
        GO = 1'b0;
        tick();
        check("end_fall", {31'd0, END}, 32'd0);
        tick();
        tick();
        check("no_extra_txn", startCount, sb + 1);
        check("bus_idle_after", {30'd0, I2C_SCLK, sdaBus}, 32'd3);
    endtask

    initial begin
        logic [23:0] d;
        int sbAbort;

        // Reset and idle with GO low
        RESET = 1'b1;
        GO = 1'b0;
        repeat (3) tick();
        check("reset_scl", {31'd0, I2C_SCLK}, 32'd1);
        check("reset_end", {31'd0, END}, 32'd0);
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (3) tick();
            check("idle_scl", {31'd0, I2C_SCLK}, 32'd1);
            check("idle_sda", {31'd0, sdaBus}, 32'd1);
            check("idle_end", {31'd0, END}, 32'd0);
            check("idle_ack", {31'd0, ACK}, 32'd0);
        end
        check("idle_no_start", startCount, 32'd0);

        // Directed transfers
        runTxn(24'h200227, 3'b000);
        runTxn(24'hC0B712, 3'b100);
        runTxn(24'hC0B712, 3'b001);
        runTxn(24'h200227, 3'b000);

        // Sequencer-style back-to-back loop
        for (int n = 0; n < 69; n++) begin
            d = 24'($urandom);
            runTxn(d, 3'($urandom_range(0, 7)));
        end

        // Abort: GO seen low while the step counter is at 20
        I2C_DATA = 24'h5A3C96;
        nackPlan = 3'b000;
        GO = 1'b1;
        sbAbort = stopCount;
        repeat (20) tick();
        GO = 1'b0;
        tick();
        check("abort_scl", {31'd0, I2C_SCLK}, 32'd1);
        check("abort_sda", {31'd0, sdaBus}, 32'd1);
        check("abort_end", {31'd0, END}, 32'd0);
        check("abort_no_stop", stopCount, sbAbort);
        tick();
        runTxn(24'h9E4D01, 3'b000);

        // RESET at step 40 with GO held; address byte NACKed beforehand
        I2C_DATA = 24'h3B7762;
        nackPlan = 3'b001;
        GO = 1'b1;
        repeat (40) tick();
        check("pre_reset_ack", {31'd0, ACK}, 32'd1);
        RESET = 1'b1;
        I2C_DATA = 24'hE18F4B;
        tick();
        check("midreset_scl", {31'd0, I2C_SCLK}, 32'd1);
        check("midreset_sda", {31'd0, sdaBus}, 32'd1);
        check("midreset_end", {31'd0, END}, 32'd0);
        check("midreset_ack", {31'd0, ACK}, 32'd0);
        tick();
        runTxn(24'hE18F4B, 3'b010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
